// File: rtl/alu_rs_entry.sv
// Single-entry ALU reservation station: holds one op, snoops the CDB for
// missing operands, issues once, frees on its own result. Option: ALU_RS_FAST_ISSUE_EN.
package alu_rs_pkg;
    typedef logic [31:0] word32_t;
    typedef enum logic [2:0] {
        TAG_NONE = 3'd0,
        ALU_1    = 3'd1,
        ALU_2    = 3'd2,
        ALU_3    = 3'd3,
        LSU_1    = 3'd4,
        MUL_1    = 3'd5
    } rs_tag_t;
    typedef enum logic [3:0] {
        ADDR = 4'd0,
        ADDI = 4'd1,
        SUBR = 4'd2,
        ANDR = 4'd3,
        ORR  = 4'd4,
        XORR = 4'd5,
        SLLR = 4'd6,
        SRLR = 4'd7
    } alu_op_t;
    typedef struct packed {
        logic    valid;
        rs_tag_t tag;
        word32_t value;
    } cdb_t;
endpackage

module alu_rs_entry
    import alu_rs_pkg::*;
#(
    parameter rs_tag_t TAG = ALU_1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    flush_i,
    input  logic    dispatch_i,
    input  alu_op_t oper_i,
    input  logic    src1_rdy_i,
    input  word32_t src1_val_i,
    input  rs_tag_t src1_tag_i,
    input  logic    src2_rdy_i,
    input  word32_t src2_val_i,
    input  rs_tag_t src2_tag_i,
    input  cdb_t    cdb_i,
    output logic    busy_o,
    output logic    ready_o,
    output alu_op_t oper_o,
    output word32_t rs1_val_o,
    output word32_t rs2_val_o
);

    typedef enum logic [1:0] {FREE, WAIT, ISSUE, EXEC} state_t;

    state_t  state_q, state_d;
    alu_op_t oper_q;
    word32_t v1_q, v2_q;
    rs_tag_t t1_q, t2_q;
    logic    p1_q, p2_q;

    logic hit1_d, hit2_d;
    logic hit1_w, hit2_w;
    logic own_hit, accept;
    logic wait_done, fast_fire;

    assign hit1_d  = !src1_rdy_i && cdb_i.valid && (cdb_i.tag == src1_tag_i);
    assign hit2_d  = !src2_rdy_i && cdb_i.valid && (cdb_i.tag == src2_tag_i);
    assign hit1_w  = p1_q && cdb_i.valid && (cdb_i.tag == t1_q);
    assign hit2_w  = p2_q && cdb_i.valid && (cdb_i.tag == t2_q);
    assign own_hit = cdb_i.valid && (cdb_i.tag == TAG);
    assign accept  = (state_q == FREE) && dispatch_i && !flush_i;

    assign wait_done = (state_q == WAIT)
                     && !(p1_q && !hit1_w)
                     && !(p2_q && !hit2_w);

`ifdef ALU_RS_FAST_ISSUE_EN
    assign fast_fire = wait_done && !flush_i;
`else
    assign fast_fire = 1'b0;
`endif

    // Next-state decode; flush dominates everything.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = FREE;
        end else begin
            unique case (1'b1)
                (state_q == FREE): begin
                    if (dispatch_i) begin
                        if ((!src1_rdy_i && !hit1_d) ||
                            (!src2_rdy_i && !hit2_d))
                            state_d = WAIT;
                        else
                            state_d = ISSUE;
                    end
                end
                (state_q == WAIT): begin
`ifdef ALU_RS_FAST_ISSUE_EN
                    if (wait_done) state_d = EXEC;
`else
                    if (wait_done) state_d = ISSUE;
`endif
                end
                (state_q == ISSUE): begin
                    state_d = own_hit ? FREE : EXEC;
                end
                (state_q == EXEC): begin
                    if (own_hit) state_d = FREE;
                end
                default: state_d = FREE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= FREE;
        else         state_q <= state_d;
    end

    // Operand capture: at dispatch (with forwarding) and from CDB in WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oper_q <= ADDR;
            v1_q   <= '0;
            v2_q   <= '0;
            t1_q   <= TAG_NONE;
            t2_q   <= TAG_NONE;
            p1_q   <= 1'b0;
            p2_q   <= 1'b0;
        end else if (accept) begin
            oper_q <= oper_i;
            t1_q   <= src1_tag_i;
            t2_q   <= src2_tag_i;
            p1_q   <= !src1_rdy_i && !hit1_d;
            p2_q   <= !src2_rdy_i && !hit2_d;
            v1_q   <= hit1_d ? cdb_i.value : src1_val_i;
            v2_q   <= hit2_d ? cdb_i.value : src2_val_i;
        end else if ((state_q == WAIT) && !flush_i) begin
            if (hit1_w) begin
                v1_q <= cdb_i.value;
                p1_q <= 1'b0;
            end
            if (hit2_w) begin
                v2_q <= cdb_i.value;
                p2_q <= 1'b0;
            end
        end
    end

    assign busy_o  = (state_q != FREE);
    assign ready_o = ((state_q == ISSUE) && !flush_i) || fast_fire;
    assign oper_o  = oper_q;

`ifdef ALU_RS_FAST_ISSUE_EN
    assign rs1_val_o = (fast_fire && hit1_w) ? cdb_i.value : v1_q;
    assign rs2_val_o = (fast_fire && hit2_w) ? cdb_i.value : v2_q;
`else
    assign rs1_val_o = v1_q;
    assign rs2_val_o = v2_q;
`endif

endmodule

// File: tb/tb_alu_rs_entry.sv
// Bench for alu_rs_entry: directed cycle table, async reset check,
// then random traffic against a transaction-level model.
module tb_alu_rs_entry;
    import alu_rs_pkg::*;

`ifdef ALU_RS_FAST_ISSUE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic    clk;
    logic    rst_n;
    logic    flush;
    logic    dispatch;
    alu_op_t oper;
    logic    src1_rdy, src2_rdy;
    word32_t src1_val, src2_val;
    rs_tag_t src1_tag, src2_tag;
    cdb_t    cdb;
    logic    busy, ready;
    alu_op_t oper_out;
    word32_t rs1_out, rs2_out;

    int total = 0;
    int bad   = 0;

    alu_rs_entry #(.TAG(ALU_1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .dispatch_i (dispatch),
        .oper_i     (oper),
        .src1_rdy_i (src1_rdy),
        .src1_val_i (src1_val),
        .src1_tag_i (src1_tag),
        .src2_rdy_i (src2_rdy),
        .src2_val_i (src2_val),
        .src2_tag_i (src2_tag),
        .cdb_i      (cdb),
        .busy_o     (busy),
        .ready_o    (ready),
        .oper_o     (oper_out),
        .rs1_val_o  (rs1_out),
        .rs2_val_o  (rs2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic    disp;
        alu_op_t op;
        logic    r1;
        word32_t v1;
        rs_tag_t t1;
        logic    r2;
        word32_t v2;
        rs_tag_t t2;
        logic    cv;
        rs_tag_t ct;
        word32_t cval;
        logic    fl;
        logic    e_busy;
        logic    e_ready;
        logic    e_chk;
        alu_op_t e_op;
        word32_t e_rs1;
        word32_t e_rs2;
    } row_t;

    row_t rows[$];
    row_t cur;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic nr();
        cur.disp = 0; cur.op = ADDR;
        cur.r1 = 0; cur.v1 = '0; cur.t1 = TAG_NONE;
        cur.r2 = 0; cur.v2 = '0; cur.t2 = TAG_NONE;
        cur.cv = 0; cur.ct = TAG_NONE; cur.cval = '0;
        cur.fl = 0;
        cur.e_busy = 0; cur.e_ready = 0; cur.e_chk = 0;
        cur.e_op = ADDR; cur.e_rs1 = '0; cur.e_rs2 = '0;
    endtask

    task automatic dsp(alu_op_t op, logic r1, word32_t v1, rs_tag_t t1,
                       logic r2, word32_t v2, rs_tag_t t2);
        cur.disp = 1; cur.op = op;
        cur.r1 = r1; cur.v1 = v1; cur.t1 = t1;
        cur.r2 = r2; cur.v2 = v2; cur.t2 = t2;
    endtask

    task automatic bus(rs_tag_t t, word32_t v);
        cur.cv = 1; cur.ct = t; cur.cval = v;
    endtask

    task automatic ex(logic b, logic r);
        cur.e_busy = b; cur.e_ready = r;
    endtask

    task automatic ev(alu_op_t op, word32_t a, word32_t b);
        cur.e_chk = 1; cur.e_op = op; cur.e_rs1 = a; cur.e_rs2 = b;
    endtask

    task automatic put();
        rows.push_back(cur);
    endtask

    task automatic idle_inputs();
        flush = 0; dispatch = 0; oper = ADDR;
        src1_rdy = 0; src1_val = '0; src1_tag = TAG_NONE;
        src2_rdy = 0; src2_val = '0; src2_tag = TAG_NONE;
        cdb = '0;
    endtask

    task automatic apply(row_t r);
        dispatch = r.disp; oper = r.op;
        src1_rdy = r.r1; src1_val = r.v1; src1_tag = r.t1;
        src2_rdy = r.r2; src2_val = r.v2; src2_tag = r.t2;
        cdb.valid = r.cv; cdb.tag = r.ct; cdb.value = r.cval;
        flush = r.fl;
    endtask

    // transaction-level reference state
    logic    m_busy, m_issued, m_pulse;
    logic    m_have1, m_have2;
    rs_tag_t m_tag1, m_tag2;
    word32_t m_v1, m_v2;
    alu_op_t m_op;

    initial begin
        // ---- directed table ----
        nr(); dsp(ADDI, 1, 32'd43, TAG_NONE, 1, 32'hFFFF_FFF4, TAG_NONE); ex(0, 0); put();
        nr(); ex(1, 1); ev(ADDI, 32'd43, 32'hFFFF_FFF4); put();
        nr(); bus(ALU_1, 32'd31); ex(1, 0); put();
        nr(); ex(0, 0); put();
        nr(); dsp(SUBR, 0, 32'hDEAD, ALU_2, 1, 32'd5, TAG_NONE); ex(0, 0); put();
        nr(); ex(1, 0); put();
        nr(); ex(1, 0); put();
        nr(); bus(ALU_2, 32'd60); ex(1, FAST);
        if (FAST) ev(SUBR, 32'd60, 32'd5);
        put();
        nr(); ex(1, !FAST);
        if (!FAST) ev(SUBR, 32'd60, 32'd5);
        put();
        nr(); bus(ALU_1, 32'd0); ex(1, 0); put();
        nr(); ex(0, 0); put();
        nr(); dsp(ANDR, 0, 32'd0, ALU_2, 0, 32'd0, ALU_2); bus(ALU_2, 32'd7); ex(0, 0); put();
        nr(); dsp(ORR, 1, 32'd1, TAG_NONE, 1, 32'd2, TAG_NONE); ex(1, 1); ev(ANDR, 32'd7, 32'd7); put();
        nr(); dsp(XORR, 1, 32'd3, TAG_NONE, 1, 32'd4, TAG_NONE); ex(1, 0); put();
        nr(); bus(ALU_1, 32'd9); ex(1, 0); put();
        nr(); ex(0, 0); put();
        nr(); dsp(ADDR, 0, 32'd0, ALU_3, 1, 32'd9, TAG_NONE); ex(0, 0); put();
        nr(); dsp(SUBR, 1, 32'd100, TAG_NONE, 1, 32'd200, TAG_NONE); ex(1, 0); put();
        nr(); bus(ALU_3, 32'h1234_5678); ex(1, FAST);
        if (FAST) ev(ADDR, 32'h1234_5678, 32'd9);
        put();
        nr(); ex(1, !FAST);
        if (!FAST) ev(ADDR, 32'h1234_5678, 32'd9);
        put();
        nr(); bus(ALU_1, 32'd0); ex(1, 0); put();
        nr(); ex(0, 0); put();
        nr(); dsp(ADDR, 0, 32'd0, ALU_2, 1, 32'd1, TAG_NONE); ex(0, 0); put();
        nr(); cur.fl = 1; ex(1, 0); put();
        nr(); bus(ALU_2, 32'd5); ex(0, 0); put();
        nr(); ex(0, 0); put();
        nr(); dsp(ADDI, 1, 32'd3, TAG_NONE, 1, 32'd4, TAG_NONE); ex(0, 0); put();
        nr(); cur.fl = 1; ex(1, 0); put();
        nr(); bus(ALU_1, 32'd0); ex(0, 0); put();
        nr(); dsp(ADDI, 1, 32'd1, TAG_NONE, 1, 32'd2, TAG_NONE); ex(0, 0); put();
        nr(); bus(ALU_1, 32'd3); ex(1, 1); ev(ADDI, 32'd1, 32'd2); put();
        nr(); dsp(ORR, 1, 32'd10, TAG_NONE, 1, 32'd11, TAG_NONE); ex(0, 0); put();
        nr(); bus(ALU_1, 32'd0); ex(1, 1); ev(ORR, 32'd10, 32'd11); put();
        nr(); ex(0, 0); put();
        nr(); dsp(ADDR, 0, 32'd0, ALU_3, 1, 32'd2, TAG_NONE); ex(0, 0); put();
        nr(); bus(ALU_3, 32'd1); cur.fl = 1; ex(1, 0); put();
        nr(); ex(0, 0); put();
        nr(); dsp(ADDI, 1, 32'd5, TAG_NONE, 1, 32'd6, TAG_NONE); cur.fl = 1; ex(0, 0); put();
        nr(); ex(0, 0); put();

        // ---- reset ----
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_oper", 32'(oper_out), 32'd0);
        chk("rst_rs1", rs1_out, 32'd0);
        chk("rst_rs2", rs2_out, 32'd0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            apply(rows[i]);
            #1;
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(rows[i].e_busy));
            chk($sformatf("row%0d_ready", i), 32'(ready), 32'(rows[i].e_ready));
            if (rows[i].e_chk) begin
                chk($sformatf("row%0d_oper", i), 32'(oper_out), 32'(rows[i].e_op));
                chk($sformatf("row%0d_rs1", i), rs1_out, rows[i].e_rs1);
                chk($sformatf("row%0d_rs2", i), rs2_out, rows[i].e_rs2);
            end
        end

        // ---- asynchronous reset mid-operation ----
        @(negedge clk);
        idle_inputs();
        dispatch = 1; oper = XORR;
        src1_rdy = 1; src1_val = 32'd77;
        src2_rdy = 0; src2_tag = ALU_3;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_busy_rst", 32'(busy), 32'd0);
        chk("mid_rs1_rst", rs1_out, 32'd0);
        @(negedge clk);
        rst_n = 1;
        cdb.valid = 1; cdb.tag = ALU_3; cdb.value = 32'd1;
        #1;
        chk("mid_ready_after", 32'(ready), 32'd0);
        chk("mid_busy_after", 32'(busy), 32'd0);

        // ---- random traffic vs model ----
        m_busy = 0; m_issued = 0; m_pulse = 0;
        m_have1 = 0; m_have2 = 0;
        m_tag1 = TAG_NONE; m_tag2 = TAG_NONE;
        m_v1 = '0; m_v2 = '0; m_op = ADDR;
        for (int n = 0; n < 3000; n++) begin
            logic    cm1, cm2, own, waiting, ff, e_rdy;
            logic    dm1, dm2;
            word32_t e1, e2;
            @(negedge clk);
            flush    = ($urandom_range(0, 19) == 0);
            dispatch = ($urandom_range(0, 2) == 0);
            oper     = alu_op_t'(4'($urandom_range(0, 7)));
            src1_rdy = 1'($urandom_range(0, 1));
            src1_val = $urandom;
            src1_tag = rs_tag_t'(3'($urandom_range(2, 3)));
            src2_rdy = 1'($urandom_range(0, 1));
            src2_val = $urandom;
            src2_tag = rs_tag_t'(3'($urandom_range(2, 3)));
            cdb.valid = ($urandom_range(0, 2) != 0);
            cdb.tag   = rs_tag_t'(3'($urandom_range(1, 3)));
            cdb.value = $urandom;
            #1;
            cm1 = cdb.valid && (cdb.tag == m_tag1);
            cm2 = cdb.valid && (cdb.tag == m_tag2);
            own = cdb.valid && (cdb.tag == ALU_1);
            waiting = m_busy && !m_issued && !m_pulse;
            ff = FAST && waiting && (m_have1 || cm1) && (m_have2 || cm2);
            e_rdy = !flush && (m_pulse || ff);
            chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'(m_busy));
            chk($sformatf("rnd%0d_ready", n), 32'(ready), 32'(e_rdy));
            if (e_rdy) begin
                e1 = (ff && !m_have1) ? cdb.value : m_v1;
                e2 = (ff && !m_have2) ? cdb.value : m_v2;
                chk($sformatf("rnd%0d_oper", n), 32'(oper_out), 32'(m_op));
                chk($sformatf("rnd%0d_rs1", n), rs1_out, e1);
                chk($sformatf("rnd%0d_rs2", n), rs2_out, e2);
            end
            if (flush) begin
                m_busy = 0; m_pulse = 0; m_issued = 0;
            end else if (!m_busy) begin
                if (dispatch) begin
                    dm1 = !src1_rdy && cdb.valid && (cdb.tag == src1_tag);
                    dm2 = !src2_rdy && cdb.valid && (cdb.tag == src2_tag);
                    m_busy = 1; m_issued = 0; m_op = oper;
                    m_tag1 = src1_tag; m_tag2 = src2_tag;
                    m_have1 = src1_rdy || dm1;
                    m_have2 = src2_rdy || dm2;
                    m_v1 = src1_rdy ? src1_val : cdb.value;
                    m_v2 = src2_rdy ? src2_val : cdb.value;
                    m_pulse = m_have1 && m_have2;
                end
            end else if (m_pulse) begin
                m_pulse = 0; m_issued = 1;
                if (own) m_busy = 0;
            end else if (m_issued) begin
                if (own) m_busy = 0;
            end else begin
                if (!m_have1 && cm1) begin m_have1 = 1; m_v1 = cdb.value; end
                if (!m_have2 && cm2) begin m_have2 = 1; m_v2 = cdb.value; end
                if (m_have1 && m_have2) begin
                    if (FAST) m_issued = 1;
                    else      m_pulse = 1;
                end
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rs_entry.md
# alu_rs_entry

Single-entry reservation station that sits directly upstream of one ALU in the out-of-order core. It accepts a dispatched ALU operation and its two source operands, which are either immediate values or tags of producers still in flight. It snoops the common data bus (CDB) to capture missing operands, then issues the operation to its ALU with a one-cycle `ready` pulse. It stays busy until the ALU broadcasts the result on the CDB under this station's tag.

## Interface
Parameters:
- `TAG` — default `ALU_1` — `rs_tag_t` identity of this station; equals the `TAG` of the ALU it feeds.

Ports:
- `clk_i` in 1 — clock.
- `rst_ni` in 1 — reset; asynchronous, active-low.
- `flush_i` in 1 — synchronous squash; entry returns to FREE.
- `dispatch_i` in 1 — dispatch valid; accepted only when `busy_o`=0.
- `oper_i` in `alu_op_t` — operation to hold.
- `src1_rdy_i` in 1 — 1: `src1_val_i` is valid; 0: wait on `src1_tag_i`.
- `src1_val_i` in `word32_t` — source 1 value.
- `src1_tag_i` in `rs_tag_t` — producer tag for source 1.
- `src2_rdy_i`, `src2_val_i`, `src2_tag_i` — same for source 2; immediates arrive sign-extended with `src2_rdy_i`=1.
- `cdb_i` in `cdb_t` — CDB snoop; fields `valid`, `tag` (`rs_tag_t`), `value` (`word32_t`).
- `busy_o` out 1 — entry occupied; dispatcher must not dispatch.
- `ready_o` out 1 — to ALU `ready_i`; one-cycle issue pulse.
- `oper_o` out `alu_op_t` — to ALU `oper_i`.
- `rs1_val_o`, `rs2_val_o` out `word32_t` — to ALU `rs1_val_i` / `rs2_val_i`.

## Operation
- Four states:
  - **FREE** — `busy_o`=0.
  - **WAIT** — at least one operand pending.
  - **ISSUE** — `ready_o`=1 for exactly one cycle.
  - **EXEC** — waiting for own result.
- **FREE**, `dispatch_i`=1:
  - Latch `oper_i` and the per-source rdy/val/tag.
  - A source with rdy=0 whose tag matches a valid `cdb_i.tag` in the same cycle is captured from `cdb_i.value` and marked ready (dispatch-cycle forwarding).
  - Both sources ready → ISSUE; otherwise → WAIT.
- **WAIT**: each cycle, every pending source whose tag equals `cdb_i.tag` with `cdb_i.valid`=1 captures `cdb_i.value`.
  - Both sources waiting on the same tag are captured together.
  - Once no source is pending → ISSUE.
- **ISSUE**: drive `ready_o`=1 with the held operands; the ALU always accepts. Next state is EXEC.
  - A CDB match on `TAG` in this cycle goes directly to FREE.
- **EXEC**: `cdb_i.valid && cdb_i.tag==TAG` → FREE.
- `busy_o` = (state != FREE).
- A dispatch while `busy_o`=1 is ignored: no state change, no latch.
- `flush_i`=1 in any state → FREE next cycle. Flush dominates dispatch and CDB in the same cycle, and suppresses any pending `ready_o`.
- Operand values are held unchanged from capture until the next dispatch.
- `oper_o`, `rs1_val_o` and `rs2_val_o` are don't-care when `ready_o`=0, but must remain stable.
- No arithmetic is done here; values pass through bit-exact.

## Timing
- Reset (`rst_ni`=0, async): state FREE; `busy_o`=0, `ready_o`=0, `oper_o`='0, `rs1_val_o`=0, `rs2_val_o`=0.
- Reset mid-operation discards the entry immediately.
- Dispatch at cycle N with both sources ready, or both forwarded in cycle N: `ready_o`=1 in N+1.
- Last operand arrives on the CDB in WAIT at cycle M: `ready_o`=1 in M+1 (default build).
- CDB match on own `TAG` at cycle K: `busy_o`=0 from K+1; a new dispatch is accepted in K+1.
- Minimum occupancy for an ALU that broadcasts one cycle after `ready_i`: 2 cycles (dispatch → ISSUE → free).

## Configuration
- `ALU_RS_FAST_ISSUE_EN`:
  - **Defined:** when the last pending operand arrives on the CDB in WAIT at cycle M, `ready_o`=1 in cycle M itself.
    - `rs*_val_o` are driven combinationally from `cdb_i.value` for the matching source.
    - State goes to EXEC at M+1, skipping ISSUE.
    - Flush in cycle M still suppresses `ready_o`.
  - **Undefined:** issue occurs in M+1 from registered operands; no combinational CDB→ALU path.
- Dispatch-cycle forwarding behaviour is identical in both builds (issue in N+1).

## Test plan
- Reset: deassert `rst_ni` after 3 cycles → `busy_o`=0, `ready_o`=0, operand outputs 0.
- Dispatch ADDI, src1=43 ready, src2=-12 ready at cycle N → `ready_o` pulse at N+1 with 43 / 0xFFFFFFF4. CDB {TAG, 31} at N+2 → `busy_o`=0 at N+3.
- Dispatch SUBR, src1 waits tag ALU_2, src2=5 ready. CDB {ALU_2, 60} 3 cycles later at M → `rs1_val_o`=60, `ready_o` at M+1; at M with `ALU_RS_FAST_ISSUE_EN`.
- Dispatch ANDR, both sources waiting on ALU_2, with CDB {ALU_2, 7} valid in the dispatch cycle N → both captured as 7, `ready_o` at N+1.
- Second dispatch while `busy_o`=1 → ignored; held `oper_o` and operands unchanged at issue.
- `flush_i` in WAIT and in ISSUE → FREE next cycle, no `ready_o` pulse. A later CDB broadcast of the old tag has no effect.
